// File: rtl/pred_raw_array.sv
// Predicated read-modify-write register array with a one-cycle registered response.
// Define PRED_RAW_ARRAY_SAT_EN to make the entry addition saturate instead of wrap.
module pred_raw_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i__valid,
    input  logic [IDX_W-1:0] i__idx,
    input  logic [WIDTH-1:0] i__constant,
    input  logic [WIDTH-1:0] i__pkt_1,
    input  logic [WIDTH-1:0] i__pkt_2,
    input  logic             i__sel1,
    input  logic             i__sel2,
    input  logic [1:0]       i__rel_op,
    input  logic             i__clr,
    output logic             o__valid,
    output logic [WIDTH-1:0] o__read,
    output logic [WIDTH-1:0] o__write,
    output logic             o__pred,
    output logic [31:0]      o__upd_count
);

    function automatic logic [WIDTH-1:0] add_ovf(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
`ifdef PRED_RAW_ARRAY_SAT_EN
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [31:0]      cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] read_q, read_d;
    logic [WIDTH-1:0] write_q, write_d;
    logic             pred_q, pred_d;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sum;
    logic             pred;
    logic             commit;

    always_comb begin
        cur    = mem_q[i__idx];
        addend = i__sel1 ? i__pkt_1 : i__constant;
        base   = i__sel2 ? '0 : cur;
        sum    = add_ovf(addend, base);
        case (i__rel_op)
            2'd0:    pred = (cur != i__pkt_2);
            2'd1:    pred = (cur <  i__pkt_2);
            2'd2:    pred = (cur >  i__pkt_2);
            default: pred = (cur == i__pkt_2);
        endcase
        commit = i__valid && pred && !i__clr;
    end

    // Next state: clear dominates any write; the response still reflects pre-clear state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = i__clr ? '0 : mem_q[i];
        end
        if (commit) begin
            mem_d[i__idx] = sum;
        end

        cnt_d = cnt_q;
        if (i__clr) begin
            cnt_d = '0;
        end else if (commit && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end

        valid_d = i__valid;
        read_d  = read_q;
        write_d = write_q;
        pred_d  = pred_q;
        if (i__valid) begin
            read_d  = cur;
            write_d = pred ? sum : cur;
            pred_d  = pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q   <= '0;
            valid_q <= 1'b0;
            read_q  <= '0;
            write_q <= '0;
            pred_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            read_q  <= read_d;
            write_q <= write_d;
            pred_q  <= pred_d;
        end
    end

    assign o__valid     = valid_q;
    assign o__read      = read_q;
    assign o__write     = write_q;
    assign o__pred      = pred_q;
    assign o__upd_count = cnt_q;

endmodule

// File: tb/tb_pred_raw_array.sv
// Directed bench for pred_raw_array with hand-computed expectations.
module tb_pred_raw_array;

    logic        clk;
    logic        rst_n;
    logic        i__valid;
    logic [3:0]  i__idx;
    logic [31:0] i__constant;
    logic [31:0] i__pkt_1;
    logic [31:0] i__pkt_2;
    logic        i__sel1;
    logic        i__sel2;
    logic [1:0]  i__rel_op;
    logic        i__clr;
    logic        o__valid;
    logic [31:0] o__read;
    logic [31:0] o__write;
    logic        o__pred;
    logic [31:0] o__upd_count;

    int vectors;
    int miscompares;

    pred_raw_array #(.WIDTH(32), .DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i__valid    (i__valid),
        .i__idx      (i__idx),
        .i__constant (i__constant),
        .i__pkt_1    (i__pkt_1),
        .i__pkt_2    (i__pkt_2),
        .i__sel1     (i__sel1),
        .i__sel2     (i__sel2),
        .i__rel_op   (i__rel_op),
        .i__clr      (i__clr),
        .o__valid    (o__valid),
        .o__read     (o__read),
        .o__write    (o__write),
        .o__pred     (o__pred),
        .o__upd_count(o__upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic resp(input string tag, input logic v, input logic [31:0] rd,
                        input logic [31:0] wr, input logic p, input logic [31:0] cnt);
        chk({tag, ".valid"}, {31'd0, o__valid}, {31'd0, v});
        chk({tag, ".read"},  o__read, rd);
        chk({tag, ".write"}, o__write, wr);
        chk({tag, ".pred"},  {31'd0, o__pred}, {31'd0, p});
        chk({tag, ".cnt"},   o__upd_count, cnt);
    endtask

    // Present one transaction, clock it, and leave the bench #1 after the edge.
    task automatic txn(input logic [3:0] idx, input logic s1, input logic [31:0] k,
                       input logic [31:0] p1, input logic s2, input logic [1:0] op,
                       input logic [31:0] p2, input logic clr);
        i__valid = 1'b1; i__idx = idx; i__sel1 = s1; i__constant = k;
        i__pkt_1 = p1; i__sel2 = s2; i__rel_op = op; i__pkt_2 = p2; i__clr = clr;
        @(posedge clk); #1;
        i__clr = 1'b0;
    endtask

    task automatic idle();
        i__valid = 1'b0; i__clr = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] ovf_exp;

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; i__valid = 1'b0; i__idx = '0; i__constant = '0; i__pkt_1 = '0;
        i__pkt_2 = '0; i__sel1 = 1'b0; i__sel2 = 1'b0; i__rel_op = '0; i__clr = 1'b0;
`ifdef PRED_RAW_ARRAY_SAT_EN
        ovf_exp = 32'hFFFF_FFFF;
`else
        ovf_exp = 32'h0000_0002;
`endif
        repeat (2) @(posedge clk);
        #1;
        resp("reset", 1'b0, 0, 0, 1'b0, 0);
        rst_n = 1'b1;

        txn(4'd3, 0, 5, 0, 0, 2'd0, 7, 0);
        resp("first", 1'b1, 0, 5, 1'b1, 1);
        idle();
        resp("idle_hold", 1'b0, 0, 5, 1'b1, 1);

        txn(4'd3, 1, 0, 1, 0, 2'd1, 7, 0);
        resp("b2b0", 1'b1, 5, 6, 1'b1, 2);
        txn(4'd3, 1, 0, 1, 0, 2'd1, 7, 0);
        resp("b2b1", 1'b1, 6, 7, 1'b1, 3);
        txn(4'd3, 1, 0, 1, 0, 2'd1, 7, 0);
        resp("b2b2", 1'b1, 7, 7, 1'b0, 3);
        txn(4'd3, 1, 0, 1, 0, 2'd1, 7, 0);
        resp("b2b3", 1'b1, 7, 7, 1'b0, 3);

        txn(4'd3, 0, 0, 0, 0, 2'd2, 6, 0);
        resp("gt", 1'b1, 7, 7, 1'b1, 4);
        txn(4'd3, 0, 1, 0, 0, 2'd3, 7, 0);
        resp("eq", 1'b1, 7, 8, 1'b1, 5);
        txn(4'd3, 0, 1, 0, 0, 2'd0, 8, 0);
        resp("ne_false", 1'b1, 8, 8, 1'b0, 5);
        txn(4'd3, 0, 2, 0, 0, 2'd1, 32'h8000_0000, 0);
        resp("lt_unsigned", 1'b1, 8, 10, 1'b1, 6);

        txn(4'd5, 0, 32'hFFFF_FFFE, 0, 1, 2'd0, 1, 0);
        resp("ovf_load", 1'b1, 0, 32'hFFFF_FFFE, 1'b1, 7);
        txn(4'd5, 0, 4, 0, 0, 2'd0, 0, 0);
        resp("ovf_add", 1'b1, 32'hFFFF_FFFE, ovf_exp, 1'b1, 8);

        txn(4'd7, 0, 100, 0, 1, 2'd0, 1, 0);
        resp("ow_load", 1'b1, 0, 100, 1'b1, 9);
        txn(4'd7, 0, 42, 0, 1, 2'd3, 100, 0);
        resp("overwrite", 1'b1, 100, 42, 1'b1, 10);

        txn(4'd2, 0, 10, 0, 1, 2'd0, 1, 0);
        resp("clr_load", 1'b1, 0, 10, 1'b1, 11);
        txn(4'd2, 1, 0, 9, 0, 2'd0, 0, 1);
        resp("clr_txn", 1'b1, 10, 19, 1'b1, 0);
        txn(4'd2, 0, 0, 0, 0, 2'd1, 0, 0);
        resp("clr_rd2", 1'b1, 0, 0, 1'b0, 0);
        txn(4'd3, 0, 0, 0, 0, 2'd1, 0, 0);
        resp("clr_rd3", 1'b1, 0, 0, 1'b0, 0);

        txn(4'd4, 0, 77, 0, 1, 2'd0, 1, 0);
        resp("pre_rst", 1'b1, 0, 77, 1'b1, 1);
        i__valid = 1'b1; i__idx = 4'd4; i__sel1 = 1'b0; i__constant = 55;
        i__sel2 = 1'b1; i__rel_op = 2'd0; i__pkt_2 = 1;
        #2 rst_n = 1'b0;
        #1;
        resp("async_rst", 1'b0, 0, 0, 1'b0, 0);
        @(posedge clk); #1;
        resp("rst_hold", 1'b0, 0, 0, 1'b0, 0);
        rst_n = 1'b1;
        txn(4'd4, 0, 0, 0, 0, 2'd1, 0, 0);
        resp("post_rst4", 1'b1, 0, 0, 1'b0, 0);
        txn(4'd5, 0, 0, 0, 0, 2'd1, 0, 0);
        resp("post_rst5", 1'b1, 0, 0, 1'b0, 0);
        idle();
        resp("final_idle", 1'b0, 0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pred_raw_array.md
PRED_RAW_ARRAY -- requirements
Module: pred_raw_array

Interface
REQ-001 Parameter WIDTH, default 32: data width of each state entry and of every data operand.
REQ-002 Parameter DEPTH, default 16: number of state entries; SHALL be a power of two, at least 2; IDX_W = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i__valid  input  1  transaction present this cycle.
REQ-006 i__idx  input  IDX_W  index of the state entry addressed.
REQ-007 i__constant  input  WIDTH  immediate addend.
REQ-008 i__pkt_1  input  WIDTH  packet-field addend.
REQ-009 i__pkt_2  input  WIDTH  packet-field predicate operand.
REQ-010 i__sel1  input  1  addend select: 0 = i__constant, 1 = i__pkt_1.
REQ-011 i__sel2  input  1  base select: 0 = current entry value, 1 = zero.
REQ-012 i__rel_op  input  2  predicate: 0 !=, 1 <, 2 >, 3 ==; compares entry (left) against i__pkt_2 (right), unsigned.
REQ-013 i__clr  input  1  synchronous clear of all entries and of the update counter.
REQ-014 o__valid  output  1  response valid.
REQ-015 o__read  output  WIDTH  entry value before the transaction.
REQ-016 o__write  output  WIDTH  entry value after the transaction.
REQ-017 o__pred  output  1  predicate result for the transaction.
REQ-018 o__upd_count  output  32  number of committed predicated updates, saturating at 2^32-1.

Function
REQ-019 For a transaction in cycle N: pred = rel_op(entry[i__idx], i__pkt_2, i__rel_op); sum = mux(i__constant, i__pkt_1, i__sel1) + mux(entry[i__idx], 0, i__sel2).
REQ-020 If pred = 1, entry[i__idx] SHALL become sum at the end of cycle N; if pred = 0, the entry is unchanged.
REQ-021 o__valid, o__read, o__write and o__pred SHALL be registered, appearing in cycle N+1 (latency 1); o__write = sum if pred = 1, else the old value.
REQ-022 With i__valid = 0, o__valid SHALL be 0 in the next cycle and the other response outputs SHALL hold their previous values.
REQ-023 Back-to-back transactions to the same index SHALL each see the value committed by the previous one; no bubbles, one transaction accepted per cycle.
REQ-024 When i__clr = 1, every entry and o__upd_count SHALL be 0 after the edge; a simultaneous valid transaction SHALL still produce its response, computed from pre-clear state, with its write suppressed and not counted.
REQ-025 o__upd_count SHALL increment by 1 per committed write (pred = 1, no clear) and hold at 2^32-1.
REQ-026 The addition is WIDTH bits; overflow handling is set by the configuration macro (REQ-030).

Reset
REQ-027 While rst_n = 0, all entries, o__upd_count, o__read, o__write and o__pred SHALL be 0, and o__valid SHALL be 0, independent of clk.
REQ-028 A transaction whose cycle coincides with reset assertion SHALL be lost with no entry modified; the first transaction is accepted on the first rising edge with rst_n = 1.

Configuration
REQ-029 The macro PRED_RAW_ARRAY_SAT_EN selects the overflow behaviour of the addition.
REQ-030 With PRED_RAW_ARRAY_SAT_EN defined, a sum exceeding 2^WIDTH-1 SHALL clamp to 2^WIDTH-1; without it, the sum SHALL wrap modulo 2^WIDTH.

Verification
REQ-031 Reset, then idx=3, sel1=0, constant=5, sel2=0, rel_op=0, pkt_2=7 -> next cycle o__valid=1, o__read=0, o__write=5, o__pred=1, o__upd_count=1.
REQ-032 Four back-to-back transactions to idx=3 adding pkt_1=1 with sel1=1 and rel_op=1, pkt_2=7, starting from entry 5 -> o__write 6, 7, then 7, 7; o__pred 1, 1, 0, 0.
REQ-033 Entry 0xFFFFFFFE plus constant 4 with pred true -> o__write=0xFFFFFFFF with PRED_RAW_ARRAY_SAT_EN defined, 0x00000002 without it.
REQ-034 i__clr=1 together with a valid add of 9 to idx=2 holding 10 -> response o__read=10, o__write=19; afterwards reading idx=2 gives o__read=0 and o__upd_count=0.
REQ-035 rst_n pulsed low mid-stream between clock edges -> outputs go to 0 immediately and all entries read back 0 after release.
REQ-036 sel2=1, constant=42, pred true on an entry holding 100 -> o__read=100, o__write=42 (overwrite).
